// File: rtl/mau_pkg.sv
// Shared definitions for the memory access unit: FSM state encoding and default widths.
package mau_pkg;

  localparam int DEF_DATA_W = 32;
  localparam int DEF_ADDR_W = 10;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_WRITE = 2'd1,
    ST_READ  = 2'd2,
    ST_RESP  = 2'd3
  } mau_state_e;

endpackage

// File: rtl/mem_access_unit.sv
// Single-request load/store unit in front of an external word-addressed data memory.
// Optional macro MAU_ALIGN_CHECK_EN rejects byte addresses that are not word aligned.
module mem_access_unit
  import mau_pkg::*;
#(
  parameter int DATA_W = DEF_DATA_W,
  parameter int ADDR_W = DEF_ADDR_W
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_write,
  input  logic [31:0]       req_addr,
  input  logic [DATA_W-1:0] req_wdata,
  output logic              resp_valid,
  input  logic              resp_ready,
  output logic [DATA_W-1:0] resp_rdata,
  output logic              resp_err,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_din,
  input  logic [DATA_W-1:0] mem_dout,
  output mau_state_e        fsm_state
);

  // Handshake: a request moves on a rising edge where req_valid and req_ready are
  // both 1; a response moves on a rising edge where resp_valid and resp_ready are both 1.
  // req_ready is high only in IDLE, so at most one request is in flight.

  logic [ADDR_W-1:0] word_addr;
  logic [DATA_W-1:0] wdata_q;
  logic              addr_bad;

  // The range/alignment check looks at the address being latched on the accept edge,
  // so an illegal request goes straight to RESP without touching memory.
`ifdef MAU_ALIGN_CHECK_EN
  assign addr_bad = (req_addr[31:ADDR_W+2] != '0) || (req_addr[1:0] != 2'b00);
`else
  logic unused_low_bits;
  assign unused_low_bits = ^req_addr[1:0];
  assign addr_bad = (req_addr[31:ADDR_W+2] != '0);
`endif

  assign mem_addr = word_addr;
  assign mem_din  = wdata_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fsm_state  <= ST_IDLE;
      req_ready  <= 1'b1;
      resp_valid <= 1'b0;
      resp_err   <= 1'b0;
      resp_rdata <= '0;
      mem_we     <= 1'b0;
      word_addr  <= '0;
      wdata_q    <= '0;
    end else begin
      case (fsm_state)
        ST_IDLE: begin
          if (req_valid) begin
            word_addr  <= req_addr[ADDR_W+1:2];
            wdata_q    <= req_wdata;
            resp_rdata <= '0;
            req_ready  <= 1'b0;
            if (addr_bad) begin
              fsm_state  <= ST_RESP;
              resp_err   <= 1'b1;
              resp_valid <= 1'b1;
            end else if (req_write) begin
              fsm_state <= ST_WRITE;
              mem_we    <= 1'b1;
            end else begin
              fsm_state <= ST_READ;
            end
          end
        end
        ST_WRITE: begin
          mem_we     <= 1'b0;
          fsm_state  <= ST_RESP;
          resp_valid <= 1'b1;
          resp_err   <= 1'b0;
        end
        ST_READ: begin
          resp_rdata <= mem_dout;
          fsm_state  <= ST_RESP;
          resp_valid <= 1'b1;
          resp_err   <= 1'b0;
        end
        ST_RESP: begin
          if (resp_ready) begin
            fsm_state  <= ST_IDLE;
            resp_valid <= 1'b0;
            resp_err   <= 1'b0;
            resp_rdata <= '0;
            req_ready  <= 1'b1;
          end
        end
        default: begin
          fsm_state <= ST_IDLE;
          mem_we    <= 1'b0;
          req_ready <= 1'b1;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mem_access_unit.sv
// Directed bench for mem_access_unit with a zero-initialised 1024-word memory model.
module tb_mem_access_unit;
  import mau_pkg::*;

  localparam int DATA_W = 32;
  localparam int ADDR_W = 10;

  logic              clk;
  logic              rst_n;
  logic              req_valid;
  logic              req_ready;
  logic              req_write;
  logic [31:0]       req_addr;
  logic [DATA_W-1:0] req_wdata;
  logic              resp_valid;
  logic              resp_ready;
  logic [DATA_W-1:0] resp_rdata;
  logic              resp_err;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_din;
  logic [DATA_W-1:0] mem_dout;
  mau_state_e        fsm_state;

  logic [DATA_W-1:0] mem [0:(1<<ADDR_W)-1];

  int n_cmp;
  int n_bad;

  mem_access_unit #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_write  (req_write),
    .req_addr   (req_addr),
    .req_wdata  (req_wdata),
    .resp_valid (resp_valid),
    .resp_ready (resp_ready),
    .resp_rdata (resp_rdata),
    .resp_err   (resp_err),
    .mem_we     (mem_we),
    .mem_addr   (mem_addr),
    .mem_din    (mem_din),
    .mem_dout   (mem_dout),
    .fsm_state  (fsm_state)
  );

  // clock / memory model
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    for (int i = 0; i < (1<<ADDR_W); i++) mem[i] = '0;
  end
  assign mem_dout = mem[mem_addr];
  always @(posedge clk) if (mem_we) mem[mem_addr] <= mem_din;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, obs, exp);
    end
  endtask

  // Issue one request and follow it to completion. Latency counts the accept edge as
  // edge 1, so a legal access responds after 2 edges and a rejected one after 1.
  task automatic run_req(input string tag, input logic wr, input logic [31:0] addr,
                         input logic [31:0] wd, input logic exp_err,
                         input logic [31:0] exp_rd, input int hold);
    int lat;
    int we_seen;
    logic [31:0] rd0;
    @(negedge clk);
    check({tag, "_ready"}, {31'd0, req_ready}, 32'd1);
    req_valid = 1'b1; req_write = wr; req_addr = addr; req_wdata = wd;
    we_seen = 0;
    @(posedge clk);
    lat = 1;
    @(negedge clk);
    req_valid = 1'b0; req_wdata = '0; req_addr = '0;
    if (mem_we) we_seen++;
    if (wr && !exp_err) begin
      check({tag, "_we"}, {31'd0, mem_we}, 32'd1);
      check({tag, "_maddr"}, {22'd0, mem_addr}, {22'd0, addr[11:2]});
      check({tag, "_mdin"}, mem_din, wd);
    end
    while (!resp_valid && lat < 8) begin
      @(posedge clk);
      lat++;
      @(negedge clk);
      if (mem_we) we_seen++;
    end
    check({tag, "_lat"}, lat, exp_err ? 32'd1 : 32'd2);
    check({tag, "_err"}, {31'd0, resp_err}, {31'd0, exp_err});
    check({tag, "_rdata"}, resp_rdata, exp_rd);
    check({tag, "_wecnt"}, we_seen, (wr && !exp_err) ? 32'd1 : 32'd0);
    rd0 = resp_rdata;
    for (int h = 0; h < hold; h++) begin
      @(posedge clk);
      @(negedge clk);
      if (mem_we) we_seen++;
      check({tag, "_hold_v"}, {31'd0, resp_valid}, 32'd1);
      check({tag, "_hold_rd"}, resp_rdata, rd0);
      check({tag, "_hold_rdy"}, {31'd0, req_ready}, 32'd0);
    end
    if (hold > 0) check({tag, "_hold_we"}, we_seen, (wr && !exp_err) ? 32'd1 : 32'd0);
    resp_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    resp_ready = 1'b0;
    check({tag, "_done_v"}, {31'd0, resp_valid}, 32'd0);
    check({tag, "_done_rdy"}, {31'd0, req_ready}, 32'd1);
  endtask

  initial begin
    int lat;
    n_cmp = 0; n_bad = 0;
    req_valid = 1'b0; req_write = 1'b0; req_addr = '0; req_wdata = '0;
    resp_ready = 1'b0;
    rst_n = 1'b0;
    #12;
    check("rst_ready", {31'd0, req_ready}, 32'd1);
    check("rst_rvalid", {31'd0, resp_valid}, 32'd0);
    check("rst_we", {31'd0, mem_we}, 32'd0);
    check("rst_maddr", {22'd0, mem_addr}, 32'd0);
    check("rst_state", {30'd0, fsm_state}, {30'd0, ST_IDLE});
    @(negedge clk);
    rst_n = 1'b1;

    run_req("st4", 1'b1, 32'h4, 32'hDEADBEEF, 1'b0, 32'h0, 0);
    check("mem1", mem[1], 32'hDEADBEEF);
    run_req("ld4", 1'b0, 32'h4, 32'h0, 1'b0, 32'hDEADBEEF, 0);
    run_req("ld8", 1'b0, 32'h8, 32'h0, 1'b0, 32'h0, 0);
    run_req("ld1000", 1'b0, 32'h1000, 32'h0, 1'b1, 32'h0, 0);
    run_req("st1000", 1'b1, 32'h1000, 32'h11111111, 1'b1, 32'h0, 0);
    check("mem0_untouched", mem[0], 32'h0);
    run_req("sthi", 1'b1, 32'h8000_0010, 32'h22222222, 1'b1, 32'h0, 0);
    run_req("stffc", 1'b1, 32'hFFC, 32'h12345678, 1'b0, 32'h0, 0);
    run_req("ldffc", 1'b0, 32'hFFC, 32'h0, 1'b0, 32'h12345678, 0);
    run_req("ld4_hold", 1'b0, 32'h4, 32'h0, 1'b0, 32'hDEADBEEF, 5);
`ifdef MAU_ALIGN_CHECK_EN
    run_req("ld6", 1'b0, 32'h6, 32'h0, 1'b1, 32'h0, 0);
    run_req("st6", 1'b1, 32'h6, 32'h55555555, 1'b1, 32'h0, 0);
    check("mem1_kept", mem[1], 32'hDEADBEEF);
`else
    run_req("ld6", 1'b0, 32'h6, 32'h0, 1'b0, 32'hDEADBEEF, 0);
    run_req("st6", 1'b1, 32'h6, 32'h55555555, 1'b0, 32'h0, 0);
    check("mem1_new", mem[1], 32'h55555555);
`endif

    // reset in the middle of a store
    @(negedge clk);
    req_valid = 1'b1; req_write = 1'b1; req_addr = 32'h10; req_wdata = 32'hAAAA5555;
    @(posedge clk);
    @(negedge clk);
    req_valid = 1'b0;
    check("rstw_we_before", {31'd0, mem_we}, 32'd1);
    #1 rst_n = 1'b0;
    #1;
    check("rstw_we", {31'd0, mem_we}, 32'd0);
    check("rstw_state", {30'd0, fsm_state}, {30'd0, ST_IDLE});
    check("rstw_ready", {31'd0, req_ready}, 32'd1);
    check("rstw_maddr", {22'd0, mem_addr}, 32'd0);
    check("rstw_mdin", mem_din, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check("rstw_noresp", {31'd0, resp_valid}, 32'd0);

    // reset while a response is pending
    @(negedge clk);
    req_valid = 1'b1; req_write = 1'b0; req_addr = 32'h2000;
    @(posedge clk);
    @(negedge clk);
    req_valid = 1'b0;
    lat = 1;
    check("rstr_pending", {31'd0, resp_valid}, 32'd1);
    rst_n = 1'b0;
    #1;
    check("rstr_v", {31'd0, resp_valid}, 32'd0);
    check("rstr_err", {31'd0, resp_err}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check("rstr_idle_v", {31'd0, resp_valid}, 32'd0);
    run_req("ld4_after", 1'b0, 32'h4, 32'h0, 1'b0,
`ifdef MAU_ALIGN_CHECK_EN
            32'hDEADBEEF,
`else
            32'h55555555,
`endif
            0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
